// File: rtl/pf_ram_arbiter.sv
// pf_ram_arbiter: sole driver of an async-read playfield RAM. It clears the RAM after
// reset, then arbitrates video tile fetches (priority) against CPU accesses with a bounded CPU wait.
module pf_ram_arbiter #(
  parameter int              AW           = 10,
  parameter int              DW           = 8,
  parameter bit              CLEAR_EN     = 1'b1,
  parameter logic [DW-1:0]   CLEAR_VAL    = {DW{1'b0}},
  parameter int              CPU_MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          busy_clear,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_cs_n,
  output logic          ram_we_n
);

  localparam int            WW       = $clog2(CPU_MAX_WAIT + 2);
  localparam logic [WW-1:0] MAX_WAIT = WW'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ACC   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_d;
  logic          cpu_win_d;
  logic          gnt_cpu_q;
  logic [AW-1:0] ram_a_q;
  logic [DW-1:0] ram_din_q;
  logic          ram_cs_n_q;
  logic          ram_we_n_q;
  logic [DW-1:0] vid_data_q;
  logic          vid_valid_q;
  logic [DW-1:0] cpu_rdata_q;
  logic          cpu_ack_q;
  logic          busy_q;

  // Grant decision and CPU starvation counter for the IDLE slot
  always_comb begin
    cpu_win_d = 1'b0;
    wait_d    = wait_q;
    if (state_q == S_IDLE) begin
      cpu_win_d = cpu_req && (!vid_req || (wait_q == MAX_WAIT));
      if (!cpu_req || cpu_win_d) begin
        wait_d = {WW{1'b0}};
      end else begin
        // here video wins against a pending CPU, so wait_q is below MAX_WAIT
        wait_d = wait_q + WW'(1);
      end
    end else begin
      wait_d = wait_q;
    end
  end

  // Controller FSM with registered RAM strobes and requester handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR_EN ? S_CLEAR : S_IDLE;
      clr_cnt_q   <= {AW{1'b0}};
      wait_q      <= {WW{1'b0}};
      gnt_cpu_q   <= 1'b0;
      ram_a_q     <= {AW{1'b0}};
      ram_din_q   <= {DW{1'b0}};
      ram_cs_n_q  <= 1'b1;
      ram_we_n_q  <= 1'b1;
      vid_data_q  <= {DW{1'b0}};
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= {DW{1'b0}};
      cpu_ack_q   <= 1'b0;
      busy_q      <= CLEAR_EN;
    end else begin
      wait_q <= wait_d;
      case (state_q)
        S_CLEAR: begin
          // the write just presented was the top address: clear is complete
          if (!ram_cs_n_q && (ram_a_q == {AW{1'b1}})) begin
            ram_cs_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            ram_a_q    <= clr_cnt_q;
            ram_din_q  <= CLEAR_VAL;
            ram_cs_n_q <= 1'b0;
            ram_we_n_q <= 1'b0;
            clr_cnt_q  <= clr_cnt_q + AW'(1);
          end
        end
        S_IDLE: begin
          if (vid_req || cpu_req) begin
            gnt_cpu_q  <= cpu_win_d;
            ram_cs_n_q <= 1'b0;
            if (cpu_win_d) begin
              ram_a_q    <= cpu_addr;
              ram_din_q  <= cpu_wdata;
              ram_we_n_q <= !cpu_we;
            end else begin
              ram_a_q    <= vid_addr;
              ram_din_q  <= {DW{1'b0}};
              ram_we_n_q <= 1'b1;
            end
            state_q <= S_ACC;
          end else begin
            ram_cs_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_ACC: begin
          ram_cs_n_q <= 1'b1;
          ram_we_n_q <= 1'b1;
          if (gnt_cpu_q) begin
            cpu_ack_q <= 1'b1;
            if (ram_we_n_q) begin
              cpu_rdata_q <= ram_dout;
            end else begin
              cpu_rdata_q <= cpu_rdata_q;
            end
          end else begin
            vid_valid_q <= 1'b1;
            vid_data_q  <= ram_dout;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          vid_valid_q <= 1'b0;
          cpu_ack_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          ram_cs_n_q  <= 1'b1;
          ram_we_n_q  <= 1'b1;
          vid_valid_q <= 1'b0;
          cpu_ack_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign vid_data   = vid_data_q;
  assign vid_valid  = vid_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign busy_clear = busy_q;
  assign ram_a      = ram_a_q;
  assign ram_din    = ram_din_q;
  assign ram_cs_n   = ram_cs_n_q;
  assign ram_we_n   = ram_we_n_q;

endmodule

// File: tb/tb_pf_ram_arbiter.sv
// Self-checking bench for pf_ram_arbiter: RAM model, timeline-based reference model,
// directed scenarios plus randomized request traffic.
`timescale 1ns/1ps
module tb_pf_ram_arbiter;
  localparam int         AW    = 10;
  localparam int         DW    = 8;
  localparam int         DEPTH = 1024;
  localparam int         MAXW  = 3;
  localparam logic [7:0] CVAL  = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          busy_clear;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_cs_n;
  logic          ram_we_n;

  pf_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy_clear(busy_clear),
    .ram_a(ram_a), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  // Async-read RAM; a write strobe held across a cycle commits at the closing edge
  logic [DW-1:0] mem [DEPTH];
  assign ram_dout = mem[ram_a];
  always @(posedge clk) if (ram_cs_n === 1'b0 && ram_we_n === 1'b0) mem[ram_a] <= ram_din;

  int checks = 0;
  int errors = 0;

  // Reference model: timeline in edges since the last reset edge
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_valid = 0;
  int            m_t, m_next, m_gt, m_loss;
  logic          m_gcpu, m_gwe;
  logic [AW-1:0] m_gaddr;
  logic [DW-1:0] m_gwdata, exp_vd, exp_cr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_valid = 1; m_t = 0; m_gt = -100; m_loss = 0;
      exp_vd = '0; exp_cr = '0; m_next = DEPTH + 2;
    end else if (m_valid != 0) begin
      m_t++;
      if (m_t == m_gt + 1) begin
        if (!m_gcpu) exp_vd = ref_mem[m_gaddr];
        else if (!m_gwe) exp_cr = ref_mem[m_gaddr];
      end
      if (m_t >= 1 && m_t <= DEPTH) ref_mem[m_t-1] = CVAL;
      if (m_t >= m_next) begin
        if (vid_req || cpu_req) begin
          m_gcpu = cpu_req && (!vid_req || m_loss == MAXW);
          m_gt = m_t; m_next = m_t + 3;
          if (m_gcpu) begin
            m_gaddr = cpu_addr; m_gwe = cpu_we; m_gwdata = cpu_wdata; m_loss = 0;
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
          end else begin
            m_gaddr = vid_addr; m_gwe = 1'b0;
            m_loss = cpu_req ? ((m_loss < MAXW) ? m_loss + 1 : MAXW) : 0;
          end
        end else begin
          m_loss = 0;
        end
      end
    end
  endtask

  task automatic compare();
    if (m_valid == 0) return;
    chk("busy_clear", 32'(busy_clear), 32'(m_t <= DEPTH));
    if (m_t >= 1 && m_t <= DEPTH) begin
      chk("clr_cs_n", 32'(ram_cs_n), 32'(0));
      chk("clr_we_n", 32'(ram_we_n), 32'(0));
      chk("clr_addr", 32'(ram_a), 32'(m_t - 1));
      chk("clr_din", 32'(ram_din), 32'(CVAL));
    end else if (m_t == m_gt) begin
      chk("acc_cs_n", 32'(ram_cs_n), 32'(0));
      chk("acc_we_n", 32'(ram_we_n), 32'(!(m_gcpu && m_gwe)));
      chk("acc_addr", 32'(ram_a), 32'(m_gaddr));
      if (m_gcpu && m_gwe) chk("acc_din", 32'(ram_din), 32'(m_gwdata));
    end else begin
      chk("idle_cs_n", 32'(ram_cs_n), 32'(1));
      chk("idle_we_n", 32'(ram_we_n), 32'(1));
    end
    if (m_t == 0) begin
      chk("rst_ram_a", 32'(ram_a), 32'(0));
      chk("rst_ram_din", 32'(ram_din), 32'(0));
    end
    chk("vid_valid", 32'(vid_valid), 32'(m_t == m_gt + 1 && !m_gcpu));
    chk("cpu_ack", 32'(cpu_ack), 32'(m_t == m_gt + 1 && m_gcpu));
    chk("vid_data", 32'(vid_data), 32'(exp_vd));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cr));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 15));
    return AW'($urandom);
  endfunction

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output int wel, output logic [DW-1:0] rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; lat = 0; wel = 0;
    do begin
      cyc(); lat++;
      if (ram_we_n === 1'b0) wel++;
    end while (cpu_ack !== 1'b1 && lat < 40);
    chk("cpu_access_done", 32'(cpu_ack), 32'(1));
    rd = cpu_rdata;
    cpu_req = 1'b0;
    cyc();
  endtask

  initial begin
    int nb, nbad, lat, wel, tv, tc, vg, r1, r2, found, early;
    logic [DW-1:0] rd, vd, cd;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(1, 255));

    // Reset state and the power-up clear
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_busy", 32'(busy_clear), 32'(1));
    chk("rst_cs_n", 32'(ram_cs_n), 32'(1));
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 1030; i++) begin
      cyc();
      if (busy_clear === 1'b1) nb++;
    end
    chk("busy_cycles", 32'(nb), 32'(1024));
    nbad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== CVAL) nbad++;
    chk("backdoor_clear", 32'(nbad), 32'(0));
    cpu_access(1'b0, 10'h3FF, 8'h00, lat, wel, rd);
    chk("first_read_3ff", 32'(rd), 32'(8'h00));

    // CPU write then read back
    cpu_access(1'b1, 10'h155, 8'hA5, lat, wel, rd);
    chk("wr_lat", 32'(lat), 32'(2));
    chk("wr_we_cycles", 32'(wel), 32'(1));
    cpu_access(1'b0, 10'h155, 8'h00, lat, wel, rd);
    chk("rd_lat", 32'(lat), 32'(2));
    chk("rd_data_155", 32'(rd), 32'(8'hA5));

    // Simultaneous video and CPU requests
    cpu_access(1'b1, 10'h020, 8'h3C, lat, wel, rd);
    cpu_access(1'b1, 10'h021, 8'hC3, lat, wel, rd);
    vid_req = 1'b1; vid_addr = 10'h020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h021;
    tv = -1; tc = -1; vd = '0; cd = '0;
    for (int n = 0; n < 20 && (tv < 0 || tc < 0); n++) begin
      cyc();
      if (vid_valid === 1'b1) begin tv = n; vd = vid_data; vid_req = 1'b0; end
      if (cpu_ack === 1'b1) begin tc = n; cd = cpu_rdata; cpu_req = 1'b0; end
    end
    chk("simul_gap", 32'(tc - tv), 32'(3));
    chk("simul_vid_first", 32'(tv >= 0 && tv < tc), 32'(1));
    chk("simul_vid_data", 32'(vd), 32'(8'h3C));
    chk("simul_cpu_data", 32'(cd), 32'(8'hC3));
    cyc();

    // Bounded CPU wait under continuous video load
    vid_req = 1'b1; vid_addr = rand_addr();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
    vg = 0; r1 = -1; r2 = -1;
    for (int n = 0; n < 80 && r2 < 0; n++) begin
      cyc();
      if (vid_valid === 1'b1) begin vg++; vid_addr = rand_addr(); end
      if (cpu_ack === 1'b1) begin
        if (r1 < 0) r1 = vg; else r2 = vg;
        vg = 0; cpu_addr = rand_addr();
      end
    end
    chk("starve_round1", 32'(r1), 32'(3));
    chk("starve_round2", 32'(r2), 32'(3));
    vid_req = 1'b0; cpu_req = 1'b0;
    cyc(); cyc(); cyc();

    // Reset in the middle of the clear, with a CPU read pending
    reset = 1'b1; cyc(); reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
    found = 0;
    for (int n = 0; n < 1100; n++) begin
      cyc();
      if (ram_cs_n === 1'b0 && ram_a === 10'h200) begin found = 1; break; end
    end
    chk("clr_200_seen", 32'(found), 32'(1));
    reset = 1'b1; cyc();
    chk("midclr_rst_cs_n", 32'(ram_cs_n), 32'(1));
    chk("midclr_rst_we_n", 32'(ram_we_n), 32'(1));
    reset = 1'b0; cyc();
    chk("restart_addr0", 32'(ram_a), 32'(0));
    nb = 1; early = 0;
    for (int n = 0; n < 1100 && busy_clear === 1'b1; n++) begin
      cyc();
      if (cpu_ack === 1'b1) early++;
      if (busy_clear === 1'b1) nb++;
    end
    chk("restart_busy_cycles", 32'(nb), 32'(1024));
    chk("no_ack_during_clear", 32'(early), 32'(0));
    lat = 0;
    while (cpu_ack !== 1'b1 && lat < 20) begin cyc(); lat++; end
    chk("pending_cpu_lat", 32'(lat), 32'(2));
    chk("pending_cpu_data", 32'(cpu_rdata), 32'(8'h00));
    cpu_req = 1'b0; cyc();

    // Reset during the access cycle of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h1F0; cpu_wdata = 8'h5A;
    found = 0;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (ram_we_n === 1'b0) begin found = 1; break; end
    end
    chk("acc_write_seen", 32'(found), 32'(1));
    reset = 1'b1; cyc();
    chk("acc_rst_no_ack", 32'(cpu_ack), 32'(0));
    reset = 1'b0;
    lat = 0;
    while (cpu_ack !== 1'b1 && lat < 1100) begin cyc(); lat++; end
    chk("rewrite_ack", 32'(cpu_ack), 32'(1));
    chk("rewrite_after_clear", 32'(busy_clear), 32'(0));
    cpu_req = 1'b0; cyc();
    cpu_access(1'b0, 10'h1F0, 8'h00, lat, wel, rd);
    chk("rewrite_data", 32'(rd), 32'(8'h5A));

    // Randomized mixed traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (vid_valid === 1'b1) begin
        vid_req = ($urandom_range(0, 1) == 1); vid_addr = rand_addr();
      end else if (!vid_req && $urandom_range(0, 3) == 0) begin
        vid_req = 1'b1; vid_addr = rand_addr();
      end
      if (cpu_ack === 1'b1) begin
        cpu_req = ($urandom_range(0, 1) == 1); cpu_addr = rand_addr();
        cpu_we = ($urandom_range(0, 1) == 1); cpu_wdata = 8'($urandom);
      end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'b1; cpu_addr = rand_addr();
        cpu_we = ($urandom_range(0, 1) == 1); cpu_wdata = 8'($urandom);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pf_ram_arbiter.md
Name: pf_ram_arbiter

Overview:
- Sits directly upstream of the 1K x 8 playfield RAM (async read, active-low cs_n/we_n) and is its only driver.
- Arbitrates CPU read/write requests against video-scanner tile fetches, video having priority with a bounded CPU wait.
- After every reset it runs a clear sequence that writes CLEAR_VAL to all 1024 locations before granting any requester.
- All RAM-side outputs are registered, so the RAM sees glitch-free address and strobes.

Parameters:
AW, 10, RAM address width (depth = 2**AW)
DW, 8, data width
CLEAR_EN, 1, 1 = run clear sequence after reset; 0 = go straight to IDLE
CLEAR_VAL, 8'h00, value written during clear
CPU_MAX_WAIT, 3, consecutive video grants a pending CPU request may lose before it wins the next slot

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vid_req  in  1  video fetch request, level, held until vid_valid
vid_addr  in  AW  video fetch address, stable while vid_req
vid_data  out  DW  fetched data, valid when vid_valid
vid_valid  out  1  one-cycle completion pulse for video
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data, valid when cpu_ack (held until next CPU read)
cpu_ack  out  1  one-cycle completion pulse for CPU
busy_clear  out  1  high while clear sequence runs
ram_a  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data (combinational from ram_a)
ram_cs_n  out  1  RAM chip select, active low
ram_we_n  out  1  RAM write enable, active low

Behaviour:
- Reset (sync, dominant over everything, including mid-clear or mid-access):
  - ram_cs_n=1, ram_we_n=1, ram_a=0, ram_din=0.
  - vid_valid=0, cpu_ack=0, vid_data=0, cpu_rdata=0, wait counter=0, clear counter=0.
  - busy_clear=CLEAR_EN; state=CLEAR if CLEAR_EN else IDLE.
  - An interrupted access is dropped with no ack; the requester keeps req high and is re-served after the restart.
- States: CLEAR, IDLE, ACC, DONE.
- CLEAR:
  - Each cycle: ram_a=counter, ram_din=CLEAR_VAL, ram_cs_n=0, ram_we_n=0; counter increments.
  - The first write is on the cycle after reset deasserts.
  - After the write to address 2**AW-1 (1024 cycles): counter wraps to 0, strobes return high, busy_clear=0, state=IDLE.
  - Requests arriving during CLEAR are ignored, stay pending, and are served afterwards.
- IDLE: if any req is high, choose the grantee and load ram_a/ram_din/ram_we_n from its inputs, ram_cs_n=0, then go to ACC.
  - Grantee is video, unless cpu_req is high and the wait counter equals CPU_MAX_WAIT, in which case CPU wins.
  - Video write is impossible: ram_we_n=1 for video grants.
  - With no request, stay in IDLE with strobes high.
- ACC (RAM access cycle):
  - Capture ram_dout into vid_data (video) or cpu_rdata (CPU read).
  - Pulse vid_valid or cpu_ack (registered, high during DONE).
  - Deassert ram_cs_n and ram_we_n; go to DONE.
  - CPU writes leave cpu_rdata unchanged.
- DONE: no grant; go to IDLE. The requester drops req on the clock edge where its ack/valid is high. A req still high in IDLE is treated as a new request.
- Latency: req sampled at IDLE edge k; strobes active during cycle k+1; ack/valid high during cycle k+2. Peak throughput is one access per 3 cycles.
- Wait counter:
  - Increments when video is granted while cpu_req is high, saturating at CPU_MAX_WAIT.
  - Clears on any CPU grant or when cpu_req is low at the IDLE decision.
- Only one of vid_valid and cpu_ack can be high in any cycle.
- Addresses never wrap or truncate: the full AW bits are passed through.

Test Plan:
- Reset, idle 1030 cycles: busy_clear high exactly 1024 cycles; backdoor read of every RAM word = 8'h00; first CPU read after clear (addr 10'h3FF) returns 8'h00.
- CPU write 8'hA5 to 10'h155, then read 10'h155: ram_we_n low exactly 1 cycle; cpu_ack 2 cycles after each request edge; cpu_rdata=8'hA5.
- vid_req and cpu_req asserted on the same edge (vid 10'h020, cpu read 10'h021): vid_valid first, cpu_ack 3 cycles later, each with correct data.
- vid_req held continuously with re-requests, cpu_req held: CPU granted after exactly 3 video grants (CPU_MAX_WAIT=3); wait counter then resets.
- Reset asserted at clear address 10'h200: strobes high next cycle; clear restarts at 10'h000 and completes 1024 cycles later; a pending cpu_req is served only after busy_clear falls.
- Reset asserted during ACC of a CPU write: no cpu_ack; the request is served after the new clear completes.
